// File: rtl/ws2812_frame_ctrl_pkg.sv
// Shared types and constants for the WS2812 frame controller.
package ws2812_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUILD = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    localparam int PIX_W   = 24;
    localparam int DIM_W   = 2;
    localparam int LEVEL_W = 5;

    localparam int DEF_REFRESH_CYCLES = 2_083_333;
    localparam int DEF_DONE_TIMEOUT   = 1_000_000;

    // Scale each GRB byte down by a right shift.
    function automatic logic [PIX_W-1:0] dim_pixel(input logic [PIX_W-1:0] color,
                                                   input logic [DIM_W-1:0] dim);
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
        g = color[23:16] >> dim;
        r = color[15:8]  >> dim;
        b = color[7:0]   >> dim;
        return {g, r, b};
    endfunction

endpackage

// File: rtl/ws2812_pixel_gen.sv
// Combinational pixel rule: decides whether LED 'index' is lit and dims it.
module ws2812_pixel_gen
    import ws2812_frame_ctrl_pkg::*;
#(
    parameter int NUM_LEDS = 16,
    parameter int IDX_W    = 4
) (
    input  logic [IDX_W-1:0]   index,
    input  logic [LEVEL_W-1:0] level,
    input  logic               mode,
    input  logic [PIX_W-1:0]   color,
    input  logic [DIM_W-1:0]   dim,
    output logic [PIX_W-1:0]   pixel
);

    logic [31:0] eff_level_s;
    logic [31:0] idx_s;
    logic        lit_s;

    // Clamp the level to the chain length, then apply the bar/dot rule.
    always_comb begin
        idx_s = 32'(index);
        if (32'(level) > 32'(NUM_LEDS)) begin
            eff_level_s = 32'(NUM_LEDS);
        end else begin
            eff_level_s = 32'(level);
        end
        if (mode == 1'b0) begin
            lit_s = (idx_s < eff_level_s);
        end else begin
            lit_s = (eff_level_s != 32'd0) && (idx_s == (eff_level_s - 32'd1));
        end
        if (lit_s) begin
            pixel = dim_pixel(color, dim);
        end else begin
            pixel = 24'h000000;
        end
    end

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// Frame controller: buffers one request, builds a frame one LED per cycle,
// hands it to the chain, waits for completion and periodically resends it.
module ws2812_frame_ctrl
    import ws2812_frame_ctrl_pkg::*;
#(
    parameter int NUM_LEDS       = 16,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
    parameter int DONE_TIMEOUT   = DEF_DONE_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [LEVEL_W-1:0]        req_level,
    input  logic                      req_mode,
    input  logic [PIX_W-1:0]          req_color,
    input  logic [DIM_W-1:0]          req_dim,
    output logic [NUM_LEDS*PIX_W-1:0] led_data,
    output logic                      chain_start,
    input  logic                      chain_done,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int          FRAME_W      = NUM_LEDS * PIX_W;
    localparam int          IDX_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);
    localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(DONE_TIMEOUT - 1);

    state_t               state_r;
    state_t               state_s;
    logic                 pending_r;
    logic [LEVEL_W-1:0]   pend_level_r;
    logic                 pend_mode_r;
    logic [PIX_W-1:0]     pend_color_r;
    logic [DIM_W-1:0]     pend_dim_r;
    logic [LEVEL_W-1:0]   cur_level_r;
    logic                 cur_mode_r;
    logic [PIX_W-1:0]     cur_color_r;
    logic [DIM_W-1:0]     cur_dim_r;
    logic [IDX_W-1:0]     idx_r;
    logic [FRAME_W-1:0]   shadow_r;
    logic [FRAME_W-1:0]   led_data_r;
    logic [31:0]          refresh_cnt_r;
    logic [31:0]          wait_cnt_r;
    logic                 timeout_err_r;
    logic [PIX_W-1:0]     pixel_s;
    logic                 consume_s;
    logic                 accept_s;
    logic                 timeout_hit_s;

    assign consume_s     = (state_r == S_IDLE) && pending_r;
    assign accept_s      = req_valid && !pending_r;
    assign timeout_hit_s = (state_r == S_WAIT) && !chain_done && (wait_cnt_r == TIMEOUT_LAST);

    ws2812_pixel_gen #(
        .NUM_LEDS (NUM_LEDS),
        .IDX_W    (IDX_W)
    ) u_pixel_gen (
        .index (idx_r),
        .level (cur_level_r),
        .mode  (cur_mode_r),
        .color (cur_color_r),
        .dim   (cur_dim_r),
        .pixel (pixel_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a pending request wins over a refresh expiry.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (pending_r) begin
                    state_s = S_BUILD;
                end else if (refresh_cnt_r == REFRESH_LAST) begin
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_BUILD: begin
                if (idx_r == IDX_LAST) begin
                    state_s = S_START;
                end else begin
                    state_s = S_BUILD;
                end
            end
            S_START: state_s = S_WAIT;
            S_WAIT: begin
                if (chain_done || (wait_cnt_r == TIMEOUT_LAST)) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_WAIT;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Output decode from the state and pending registers only.
    always_comb begin
        chain_start = 1'b0;
        busy        = 1'b1;
        case (state_r)
            S_IDLE:  busy = 1'b0;
            S_START: chain_start = 1'b1;
            default: busy = 1'b1;
        endcase
        req_ready   = ~pending_r;
        led_data    = led_data_r;
        timeout_err = timeout_err_r;
    end

    // Single-entry request buffer; it empties when the FSM consumes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r    <= 1'b0;
            pend_level_r <= '0;
            pend_mode_r  <= 1'b0;
            pend_color_r <= '0;
            pend_dim_r   <= '0;
        end else if (consume_s) begin
            pending_r <= 1'b0;
        end else if (accept_s) begin
            pending_r    <= 1'b1;
            pend_level_r <= req_level;
            pend_mode_r  <= req_mode;
            pend_color_r <= req_color;
            pend_dim_r   <= req_dim;
        end
    end

    // Working copy of the request being built, so the buffer can refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_level_r <= '0;
            cur_mode_r  <= 1'b0;
            cur_color_r <= '0;
            cur_dim_r   <= '0;
        end else if (consume_s) begin
            cur_level_r <= pend_level_r;
            cur_mode_r  <= pend_mode_r;
            cur_color_r <= pend_color_r;
            cur_dim_r   <= pend_dim_r;
        end
    end

    // Build one LED per cycle into the shadow buffer (LED0 at the top).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r    <= '0;
            shadow_r <= '0;
        end else if (state_r == S_BUILD) begin
            idx_r <= idx_r + 1'b1;
            shadow_r[(NUM_LEDS - 1 - int'(idx_r)) * PIX_W +: PIX_W] <= pixel_s;
        end else begin
            idx_r <= '0;
        end
    end

    // Publish the frame at the end of the start cycle; held through the wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_data_r <= '0;
        end else if (state_r == S_START) begin
            led_data_r <= shadow_r;
        end
    end

    // Refresh counter: zero while chain_start is high, saturating afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt_r <= 32'd0;
        end else if (state_s == S_START) begin
            refresh_cnt_r <= 32'd0;
        end else if (refresh_cnt_r != REFRESH_LAST) begin
            refresh_cnt_r <= refresh_cnt_r + 32'd1;
        end
    end

    // Wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r    <= 32'd0;
            timeout_err_r <= 1'b0;
        end else begin
            if (state_r == S_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 32'd1;
            end else begin
                wait_cnt_r <= 32'd0;
            end
            if (timeout_hit_s) begin
                timeout_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Bench for ws2812_frame_ctrl: directed scenarios plus random requests
// checked against a frame model computed from the pixel rule.
module tb_ws2812_frame_ctrl;

    localparam int NUM = 16;
    localparam int LW  = NUM * 24;
    localparam int REFRESH = 1000;
    localparam int TIMEOUT = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [4:0]    req_level = 5'd0;
    logic          req_mode = 1'b0;
    logic [23:0]   req_color = 24'h0;
    logic [1:0]    req_dim = 2'd0;
    logic [LW-1:0] led_data;
    logic          chain_start;
    logic          chain_done = 1'b0;
    logic          busy;
    logic          timeout_err;

    int tests = 0;
    int fails = 0;
    int chain_delay = 20;
    bit chain_en = 1'b1;
    bit skip_stable = 1'b0;
    int viol = 0;
    int starts_total = 0;
    logic exp_err = 1'b0;

    always #4 clk = ~clk;

    ws2812_frame_ctrl #(
        .NUM_LEDS       (NUM),
        .REFRESH_CYCLES (REFRESH),
        .DONE_TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_level   (req_level),
        .req_mode    (req_mode),
        .req_color   (req_color),
        .req_dim     (req_dim),
        .led_data    (led_data),
        .chain_start (chain_start),
        .chain_done  (chain_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Chain stand-in: answers each chain_start with one chain_done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (chain_start === 1'b1 && chain_en) begin
                repeat (chain_delay) @(negedge clk);
                chain_done = 1'b1;
                @(negedge clk);
                chain_done = 1'b0;
            end
        end
    end

    // Monitor: led_data may only move right after a chain_start sample.
    initial begin
        logic [LW-1:0] prev_led;
        logic          prev_cs;
        prev_led = '0;
        prev_cs  = 1'b0;
        forever begin
            @(negedge clk);
            if (!skip_stable && rst_n === 1'b1 && led_data !== prev_led && prev_cs !== 1'b1)
                viol++;
            if (chain_start === 1'b1)
                starts_total++;
            prev_led = led_data;
            prev_cs  = chain_start;
        end
    end

    // Watchdog.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame straight from the lighting rule.
    function automatic logic [LW-1:0] model_frame(input int lv, input int md,
                                                  input logic [23:0] col, input int dm);
        logic [LW-1:0] f;
        int            l;
        logic [7:0]    g, r, b;
        f = '0;
        l = (lv > NUM) ? NUM : lv;
        g = col[23:16] >> dm;
        r = col[15:8]  >> dm;
        b = col[7:0]   >> dm;
        for (int i = 0; i < NUM; i++) begin
            if ((md != 0) ? (l > 0 && i == l - 1) : (i < l))
                f[(NUM - 1 - i) * 24 +: 24] = {g, r, b};
        end
        return f;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_req(input int lv, input int md, input logic [23:0] col, input int dm);
        int n;
        n = 0;
        req_level = 5'(lv);
        req_mode  = 1'(md);
        req_color = col;
        req_dim   = 2'(dm);
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_start(input int bound, output int n, output int busy_at);
        n = 0;
        busy_at = -1;
        while (chain_start !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
            if (busy_at < 0 && busy === 1'b1) busy_at = n;
        end
        chk("start_seen", chain_start, 1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("back_idle", busy, 0);
    endtask

    task automatic run_frame(input int lv, input int md, input logic [23:0] col, input int dm,
                             output logic [LW-1:0] got);
        int n, b;
        send_req(lv, md, col, dm);
        wait_start(300, n, b);
        chk("build_len", n - b, NUM);
        step(1);
        got = led_data;
        chk("frame", led_data, model_frame(lv, md, col, dm));
        wait_idle(300);
        chk("err_flag", timeout_err, exp_err);
    endtask

    initial begin
        logic [LW-1:0] got, fa, fb, fc;
        int n, b;

        // Reset state.
        step(2);
        chk("rst_led", led_data, 0);
        chk("rst_start", chain_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", timeout_err, 0);
        rst_n = 1'b1;
        step(2);
        chk("rst_ready", req_ready, 1);

        // Bar request.
        run_frame(5, 0, 24'hFF0000, 0, got);
        chk("bar_lit", got[LW-1 -: 120], {5{24'hFF0000}});
        chk("bar_dark", got[LW-121:0], 0);

        // Dot request, then level 0.
        run_frame(16, 1, 24'h00FF80, 2, got);
        chk("dot_led15", got[23:0], 24'h003F20);
        chk("dot_rest", got[LW-1:24], 0);
        run_frame(0, 1, 24'h123456, 0, got);
        chk("dot_zero", got, 0);

        // Saturation.
        run_frame(20, 0, 24'h0A0B0C, 0, got);
        chk("sat_all", got, {16{24'h0A0B0C}});

        // Back-pressure: B accepted during A's wait, C held until B is consumed.
        fa = model_frame(3, 0, 24'h112233, 0);
        fb = model_frame(9, 1, 24'h445566, 1);
        fc = model_frame(12, 0, 24'h778899, 3);
        send_req(3, 0, 24'h112233, 0);
        wait_start(300, n, b);
        step(1);
        chk("b2b_frame_a", led_data, fa);
        send_req(9, 1, 24'h445566, 1);
        req_level = 5'd12;
        req_mode  = 1'b0;
        req_color = 24'h778899;
        req_dim   = 2'd3;
        req_valid = 1'b1;
        chk("b2b_held", req_ready, 0);
        chk("b2b_held_busy", busy, 1);
        n = 0;
        while (req_ready !== 1'b1 && n < 500) begin
            step(1);
            n++;
        end
        chk("b2b_ready_back", req_ready, 1);
        chk("b2b_busy_b", busy, 1);
        chk("b2b_led_a_kept", led_data, fa);
        step(1);
        req_valid = 1'b0;
        wait_start(300, n, b);
        step(1);
        chk("b2b_frame_b", led_data, fb);
        wait_idle(300);
        wait_start(300, n, b);
        step(1);
        chk("b2b_frame_c", led_data, fc);
        wait_idle(300);

        // Refresh with no requests.
        wait_start(1200, n, b);
        n = 0;
        do begin
            step(1);
            n++;
        end while (chain_start !== 1'b1 && n < 1200);
        chk("refresh_period", n, REFRESH);
        step(1);
        chk("refresh_frame", led_data, fc);
        wait_idle(300);

        // Timeout with the chain silent.
        chain_en = 1'b0;
        send_req(4, 0, 24'h202020, 1);
        wait_start(300, n, b);
        for (int k = 1; k <= TIMEOUT; k++) step(1);
        chk("to_err_before", timeout_err, 0);
        chk("to_busy_before", busy, 1);
        step(1);
        chk("to_err_set", timeout_err, 1);
        chk("to_idle", busy, 0);
        exp_err  = 1'b1;
        chain_en = 1'b1;
        run_frame(2, 1, 24'h0000FF, 0, got);

        // Reset during build cycle 7.
        send_req(7, 0, 24'hABCDEF, 0);
        n = 0;
        while (busy !== 1'b1 && n < 50) begin
            step(1);
            n++;
        end
        step(6);
        skip_stable = 1'b1;
        step(1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_led", led_data, 0);
        chk("mid_rst_start", chain_start, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", timeout_err, 0);
        chk("mid_rst_ready", req_ready, 1);
        step(1);
        rst_n   = 1'b1;
        exp_err = 1'b0;
        step(2);
        skip_stable = 1'b0;
        b = starts_total;
        step(300);
        chk("mid_rst_no_start", starts_total - b, 0);
        chk("mid_rst_idle", busy, 0);

        // Random requests against the model.
        for (int r = 0; r < 12; r++) begin
            step($urandom_range(0, 10));
            run_frame($urandom_range(0, 20), $urandom_range(0, 1), 24'($urandom),
                      $urandom_range(0, 3), got);
        end

        chk("led_stable", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
